uop_result_sink: RTL
====================

UOP_RESULT_SINK -- requirements
Module: uop_result_sink

Interface
REQ-001 Parameter W, 64, data width of uop block results.
REQ-002 Parameter LATENCY, 2, cycles from an accepted launch to its result on dst_i (input register plus PIPE_STAGES of the block); legal range 1..8.
REQ-003 Parameter DEPTH, 4, result buffer entries; power of two, 2..16.
REQ-004 clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid_i  input  1  the issuer presents an operand set to the uop block this cycle.
REQ-007 in_ready_o  output  1  the sink grants a launch this cycle; launch = in_valid_i & in_ready_o.
REQ-008 dst_i  input  W  result bus from the uop block.
REQ-009 out_valid_o  output  1  buffered result available.
REQ-010 out_ready_i  input  1  downstream accepts the result; pop = out_valid_o & out_ready_i.
REQ-011 out_data_o  output  W  oldest buffered result.
REQ-012 clear_i  input  1  synchronous clear of sig_o, count_o and err_o.
REQ-013 sig_o  output  W  running result signature.
REQ-014 count_o  output  32  number of results popped.
REQ-015 err_o  output  1  sticky: a push was attempted while the buffer was full.

Function
REQ-016 A LATENCY-bit token shift register shall enter launch at stage 0 and shift one stage per cycle; push = last stage, so a launch in cycle t samples dst_i in cycle t+LATENCY.
REQ-017 The pushed result shall appear on out_data_o with out_valid_o=1 in cycle t+LATENCY+1 when the buffer was empty (no bypass).
REQ-018 inflight = popcount of the token register; in_ready_o = (fill + inflight) < DEPTH, computed from registered state only, with no dependence on in_valid_i or out_ready_i.
REQ-019 The credit rule shall guarantee that no push occurs while the buffer is full; if one does occur, the data shall be dropped and err_o set.
REQ-020 Push and pop in the same cycle: the buffer shall write and read, fill shall remain unchanged, and this shall be legal at full.
REQ-021 A pop while empty shall have no effect.
REQ-022 Pointers shall be log2(DEPTH) bits and wrap modulo DEPTH; fill shall be log2(DEPTH)+1 bits.
REQ-023 out_data_o shall hold steady while out_valid_o=1 and out_ready_i=0.
REQ-024 On each push: sig_o <= {sig_o[W-2:0], sig_o[W-1]} ^ dst_i.
REQ-025 On each pop, count_o shall increment by 1 and wrap at 2^32.
REQ-026 When clear_i coincides with a push or pop, the clear shall win for sig_o, count_o and err_o; buffer contents and tokens are unaffected by clear_i.
REQ-027 The block shall never apply backpressure to dst_i; results are accepted unconditionally on token arrival.

Reset
REQ-028 rst_n=0 shall asynchronously clear tokens, pointers, fill, sig_o, count_o and err_o; out_valid_o=0.
REQ-029 After reset, in_ready_o = 1.
REQ-030 Reset mid-operation shall discard all in-flight tokens; dst_i values of launches issued before reset shall never be pushed.
REQ-031 Buffer storage shall not be reset.

Structure
REQ-032 The signature step function and the LATENCY/DEPTH legal-range constants shall live in uop_pkg.
REQ-033 The buffer shall be one sub-module, uop_sink_fifo (push, pop, data, full, empty, fill); token tracking, credits and signature shall remain in uop_result_sink.

Verification
REQ-034 Single launch, LATENCY=2, dst_i=64'hA5 in cycle t+2, out_ready_i=1 -> out_valid_o=1 with out_data_o=64'hA5 in cycle t+3 only; sig_o=64'hA5; count_o=1.
REQ-035 Back-to-back launches with out_ready_i=0 -> exactly 4 launches are accepted, then in_ready_o=0; 4 results are buffered in order; err_o=0.
REQ-036 Full buffer, then out_ready_i=1 held with continuous in_valid_i -> 1 result/cycle steady state, data order preserved across pointer wrap (at least 10 results), fill never exceeds 4.
REQ-037 Push values 1 then 2 after reset -> sig_o = 64'h0000_0000_0000_0000 -> 64'h1 -> (64'h2 ^ 64'h2) = 64'h0.
REQ-038 Assert rst_n=0 for 1 cycle with 2 tokens in flight -> no push afterward; out_valid_o stays 0; in_ready_o=1; count_o=0.
REQ-039 clear_i asserted in the same cycle as a pop with count_o=5 -> count_o=0 in the next cycle, and the popped data is delivered normally.

Source files
------------

// File: rtl/uop_pkg.sv
// ----------------------------------------------------------------------------
// uop_pkg
// Shared constants and helpers for the uop result sink.
//   LATENCY_MIN/MAX : legal launch-to-result latency range
//   DEPTH_MIN/MAX   : legal result buffer depth range
//   SIG_W_MAX       : widest result the signature helper handles
//   sig_step()      : one step of the running result signature
// ----------------------------------------------------------------------------
package uop_pkg;

    localparam int unsigned LATENCY_MIN = 1;
    localparam int unsigned LATENCY_MAX = 8;
    localparam int unsigned DEPTH_MIN   = 2;
    localparam int unsigned DEPTH_MAX   = 16;
    localparam int unsigned SIG_W_MAX   = 64;

    // Rotate-left-by-one of the low w bits of sig, then XOR in dst.
    // Operands narrower than SIG_W_MAX arrive zero-extended; bits at and
    // above w are masked off so the caller can simply take the low w bits.
    function automatic logic [SIG_W_MAX-1:0] sig_step(
        input logic [SIG_W_MAX-1:0] sig,
        input logic [SIG_W_MAX-1:0] dst,
        input int unsigned          w
    );
        logic [SIG_W_MAX-1:0] mask;
        logic [SIG_W_MAX-1:0] rot;
        mask = (w >= SIG_W_MAX) ? '1 : ((SIG_W_MAX'(1) << w) - SIG_W_MAX'(1));
        rot  = ((sig << 1) | (sig >> (w - 1))) & mask;
        return rot ^ (dst & mask);
    endfunction

endpackage

// File: rtl/uop_sink_fifo.sv
// ----------------------------------------------------------------------------
// uop_sink_fifo
// Circular result buffer, DEPTH entries of W bits, no bypass.
//   clk, rst_n : clock, asynchronous active-low reset (pointers/fill only)
//   push       : write wdata this cycle (dropped if full and not popping)
//   pop        : remove the oldest entry (ignored when empty)
//   wdata      : data to write
//   rdata      : oldest entry, stable until popped
//   full/empty : occupancy flags
//   fill       : number of valid entries, 0..DEPTH
// ----------------------------------------------------------------------------
module uop_sink_fifo
    import uop_pkg::*;
#(
    parameter int unsigned W     = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   fill
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   fill_q;
    logic          do_push;
    logic          do_pop;

    assign full    = (fill_q == (AW+1)'(DEPTH));
    assign empty   = (fill_q == '0);
    assign fill    = fill_q;
    assign rdata   = mem[rd_ptr];

    // A push at full is only taken when a pop frees the slot in the same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   fill_q <= fill_q + (AW+1)'(1);
                2'b01:   fill_q <= fill_q - (AW+1)'(1);
                default: fill_q <= fill_q;
            endcase
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uop_result_sink.sv
// ----------------------------------------------------------------------------
// uop_result_sink
// Issues credits to a fixed-latency uop block, captures its results into a
// buffer when their launch token arrives, and keeps a signature and pop count.
//   clk, rst_n              : clock, asynchronous active-low reset
//   in_valid_i / in_ready_o : launch handshake toward the issuer
//   dst_i                   : uop block result bus, sampled on token arrival
//   out_valid_o/out_ready_i : result handshake toward downstream
//   out_data_o              : oldest buffered result
//   clear_i                 : synchronous clear of sig_o, count_o, err_o
//   sig_o                   : running signature of pushed results
//   count_o                 : results popped, wraps at 2^32
//   err_o                   : sticky overflow (push attempted while full)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready_o depends on registered state only; out_valid_o stays high
// and out_data_o stays stable until the transfer happens.
// ----------------------------------------------------------------------------
module uop_result_sink
    import uop_pkg::*;
#(
    parameter int unsigned W       = 64,
    parameter int unsigned LATENCY = 2,
    parameter int unsigned DEPTH   = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [W-1:0]  dst_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [W-1:0]  out_data_o,
    input  logic          clear_i,
    output logic [W-1:0]  sig_o,
    output logic [31:0]   count_o,
    output logic          err_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX ||
        DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX ||
        (DEPTH & (DEPTH - 1)) != 0 || W > SIG_W_MAX || W < 2) begin : g_bad_param
        $error("uop_result_sink: illegal parameter combination");
    end

    logic [LATENCY-1:0]   tok_q;
    logic [LATENCY-1:0]   tok_d;
    logic                 launch;
    logic                 push;
    logic                 pop;
    logic                 overflow;
    logic                 full;
    logic                 empty;
    logic [AW:0]          fill;
    logic [31:0]          credits_used;
    logic [SIG_W_MAX-1:0] sig_wide;

    // Every buffered result and every token in flight holds a credit, so a
    // launch is granted only if its result is guaranteed a slot.
    assign credits_used = 32'(fill) + 32'($countones(tok_q));
    assign in_ready_o   = (credits_used < DEPTH);
    assign launch       = in_valid_i & in_ready_o;

    always_comb begin
        tok_d    = '0;
        tok_d[0] = launch;
        for (int i = 1; i < LATENCY; i++) begin
            tok_d[i] = tok_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tok_q <= '0;
        else        tok_q <= tok_d;
    end

    // The result is taken unconditionally when its token leaves the last stage.
    assign push        = tok_q[LATENCY-1];
    assign out_valid_o = ~empty;
    assign pop         = out_valid_o & out_ready_i;
    // Full with a pop in the same cycle is a legal pass-through, not overflow.
    assign overflow    = push & full & ~out_ready_i;

    uop_sink_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (dst_i),
        .rdata (out_data_o),
        .full  (full),
        .empty (empty),
        .fill  (fill)
    );

    assign sig_wide = sig_step(SIG_W_MAX'(sig_o), SIG_W_MAX'(dst_i), W);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_o   <= '0;
            count_o <= '0;
            err_o   <= 1'b0;
        end else if (clear_i) begin
            sig_o   <= '0;
            count_o <= '0;
            err_o   <= 1'b0;
        end else begin
            if (push)     sig_o   <= sig_wide[W-1:0];
            if (pop)      count_o <= count_o + 32'd1;
            if (overflow) err_o   <= 1'b1;
        end
    end

endmodule
